// File: rtl/status_led_arbiter.sv
// Status LED blink-code arbiter.
// Four requesters share one LED. An eligible requester (req high, nonzero
// code) is granted round-robin. The LED then plays N on-pulses separated by
// OFF intervals, followed by a GAP, before the next arbitration. A running
// sequence is never preempted. enable=0 freezes every register.
module status_led_arbiter #(
    parameter int TICK_COUNTS = 100_000,
    parameter int ON_TICKS    = 250,
    parameter int OFF_TICKS   = 250,
    parameter int GAP_TICKS   = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [3:0]  req,
    input  logic [15:0] code_in,
    output logic        led_out,
    output logic [3:0]  grant,
    output logic        busy,
    output logic        done
);

    // ------------------------------------------------------------------
    // Widths and terminal counts
    // ------------------------------------------------------------------
    localparam int PRESC_W   = (TICK_COUNTS > 1) ? $clog2(TICK_COUNTS) : 1;
    localparam int MAX_PHASE = (ON_TICKS > OFF_TICKS)
                             ? ((ON_TICKS  > GAP_TICKS) ? ON_TICKS  : GAP_TICKS)
                             : ((OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS);
    localparam int PHASE_W   = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_COUNTS - 1);
    localparam logic [PHASE_W-1:0] ON_LAST    = PHASE_W'(ON_TICKS - 1);
    localparam logic [PHASE_W-1:0] OFF_LAST   = PHASE_W'(OFF_TICKS - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST   = PHASE_W'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    state_t               state_q,     state_d;
    logic [PRESC_W-1:0]   presc_q,     presc_d;
    logic [PHASE_W-1:0]   phase_q,     phase_d;
    logic [3:0]           remaining_q, remaining_d;
    logic [1:0]           rr_ptr_q,    rr_ptr_d;
    logic [3:0]           grant_q,     grant_d;
    logic                 led_q,       led_d;
    logic                 done_q,      done_d;

    // ------------------------------------------------------------------
    // Eligibility and round-robin selection
    // ------------------------------------------------------------------
    logic [3:0] eligible;
    logic       hit;
    logic [1:0] sel;
    logic [1:0] cand;
    logic [3:0] sel_code;
    logic [3:0] sel_onehot;
    logic       tick;

    // A zero code means "nothing to show", so it never wins arbitration.
    for (genvar gi = 0; gi < 4; gi++) begin : g_elig
        assign eligible[gi] = req[gi] & (code_in[4*gi +: 4] != 4'd0);
    end

    // Search starting at rr_ptr and wrapping; first eligible requester wins.
    always_comb begin
        hit  = 1'b0;
        sel  = rr_ptr_q;
        cand = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = rr_ptr_q + 2'(k);
            if (!hit && eligible[cand]) begin
                hit = 1'b1;
                sel = cand;
            end
        end
    end

    assign sel_code   = code_in[{sel, 2'b00} +: 4];
    assign sel_onehot = 4'b0001 << sel;

    // Timebase tick: the prescaler only runs while a sequence is playing.
    assign tick = (state_q != S_IDLE) && (presc_q == PRESC_LAST);

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    // Everything holds unless enable is high; done is a pulse and drops
    // back to 0 on every edge, so a freeze can never stretch it.
    always_comb begin
        state_d     = state_q;
        presc_d     = presc_q;
        phase_d     = phase_q;
        remaining_d = remaining_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        led_d       = led_q;
        done_d      = 1'b0;

        if (enable) begin
            if (state_q != S_IDLE) begin
                presc_d = tick ? '0 : presc_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (hit) begin
                        grant_d     = sel_onehot;
                        remaining_d = sel_code;
                        led_d       = 1'b1;
                        state_d     = S_ON;
                        phase_d     = '0;
                        presc_d     = '0;
                        rr_ptr_d    = sel + 2'd1;
                    end
                end

                S_ON: begin
                    if (tick) begin
                        if (phase_q == ON_LAST) begin
                            phase_d     = '0;
                            led_d       = 1'b0;
                            remaining_d = remaining_q - 4'd1;
                            state_d     = (remaining_q == 4'd1) ? S_GAP : S_OFF;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end

                S_OFF: begin
                    if (tick) begin
                        if (phase_q == OFF_LAST) begin
                            phase_d = '0;
                            led_d   = 1'b1;
                            state_d = S_ON;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end

                S_GAP: begin
                    if (tick) begin
                        if (phase_q == GAP_LAST) begin
                            phase_d = '0;
                            done_d  = 1'b1;
                            grant_d = '0;
                            state_d = S_IDLE;
                        end else begin
                            phase_d = phase_q + 1'b1;
                        end
                    end
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            presc_q     <= '0;
            phase_q     <= '0;
            remaining_q <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            led_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            remaining_q <= remaining_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            led_q       <= led_d;
            done_q      <= done_d;
        end
    end

    assign led_out = led_q;
    assign grant   = grant_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_status_led_arbiter.sv
// Directed bench for status_led_arbiter with a scoreboard of expected
// grant sequences; each sequence is checked cycle by cycle against a
// timing model built from the tick parameters.
module tb_status_led_arbiter;

    localparam int T    = 4;
    localparam int ON   = 2;
    localparam int OFF  = 2;
    localparam int GAP  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req;
    logic [15:0] code_in;
    logic        led_out;
    logic [3:0]  grant;
    logic        busy;
    logic        done;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0] g;
        int         n;
    } sb_t;

    sb_t exp_q[$];

    status_led_arbiter #(
        .TICK_COUNTS(T),
        .ON_TICKS(ON),
        .OFF_TICKS(OFF),
        .GAP_TICKS(GAP)
    ) dut (
        .clk(clk),
        .rst(rst),
        .enable(enable),
        .req(req),
        .code_in(code_in),
        .led_out(led_out),
        .grant(grant),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, 32'(grant),   32'd0);
        chk({tag, "_led"},   32'(led_out), 32'd0);
        chk({tag, "_busy"},  32'(busy),    32'd0);
        chk({tag, "_done"},  32'(done),    32'd0);
    endtask

    // Called at the falling edge of the first cycle in which the grant is
    // expected. Returns at the falling edge of the done cycle, or right
    // after the reset edge when abort_at is reached.
    task automatic play(input int freeze_at, input int freeze_len,
                        input int drop_at, input logic [3:0] drop_req,
                        input logic [15:0] drop_code, input int abort_at);
        sb_t  e;
        int   t;
        int   per;
        int   total;
        logic exp_led;
        if (exp_q.size() == 0) begin
            checks++;
            fails++;
            $error("FAIL scoreboard_empty: observed=0 expected=1 entries");
            return;
        end
        e     = exp_q.pop_front();
        per   = (ON + OFF) * T;
        total = (e.n * ON + (e.n - 1) * OFF + GAP) * T;
        t     = 0;
        for (int c = 0; c < total + freeze_len + 2; c++) begin
            if (t < total) begin
                exp_led = ((t / per) < e.n) && ((t % per) < ON * T);
                chk("seq_grant", 32'(grant),   32'(e.g));
                chk("seq_led",   32'(led_out), 32'(exp_led));
                chk("seq_busy",  32'(busy),    32'd1);
                chk("seq_done",  32'(done),    32'd0);
            end else begin
                chk("end_done",  32'(done),    32'd1);
                chk("end_grant", 32'(grant),   32'd0);
                chk("end_led",   32'(led_out), 32'd0);
                chk("end_busy",  32'(busy),    32'd0);
                $display("txn grant=%b pulses=%0d active_cycles=%0d wall_cycles=%0d",
                         e.g, e.n, total, c);
                return;
            end
            if (c == drop_at) begin
                req     = drop_req;
                code_in = drop_code;
            end
            enable = !((c >= freeze_at) && (c < freeze_at + freeze_len));
            if (c == abort_at) rst = 1'b1;
            @(posedge clk);
            if (c == abort_at) begin
                $display("txn grant=%b pulses=%0d aborted_by_reset_at=%0d", e.g, e.n, c);
                return;
            end
            if (enable) t++;
            @(negedge clk);
        end
        checks++;
        fails++;
        $error("FAIL seq_timeout: observed=t%0d expected=t%0d", t, total);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b1;
        req     = 4'b0000;
        code_in = 16'h0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_idle("idle_noreq");

        // Single requester, code 3.
        req     = 4'b0001;
        code_in = 16'h0003;
        exp_q.push_back('{4'b0001, 3});
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, -1, 4'b0, 16'h0, -1);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk_idle("after_a");

        // Reset pointer, then all four requesting code 1: strict rotation.
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_idle("reset2");
        rst     = 1'b0;
        req     = 4'b1111;
        code_in = 16'h1111;
        exp_q.push_back('{4'b0001, 1});
        exp_q.push_back('{4'b0010, 1});
        exp_q.push_back('{4'b0100, 1});
        exp_q.push_back('{4'b1000, 1});
        exp_q.push_back('{4'b0001, 1});
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            play(-1, 0, -1, 4'b0, 16'h0, -1);
            if (i == 4) req = 4'b0000;
            @(posedge clk);
            @(negedge clk);
        end
        chk_idle("after_rr");

        // Requester 2 has code 0, so only requester 1 is ever granted.
        req     = 4'b0110;
        code_in = 16'h0020;
        exp_q.push_back('{4'b0010, 2});
        exp_q.push_back('{4'b0010, 2});
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, -1, 4'b0, 16'h0, -1);
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, -1, 4'b0, 16'h0, -1);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk_idle("after_zero_code");

        // Non-preemptive: drop req, change code, raise a new requester mid-run.
        req     = 4'b0010;
        code_in = 16'h0020;
        exp_q.push_back('{4'b0010, 2});
        exp_q.push_back('{4'b1000, 1});
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, 3, 4'b1000, 16'h1050, -1);
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, -1, 4'b0, 16'h0, -1);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk_idle("after_nonpreempt");

        // Freeze for 10 cycles starting at cycle 5 of the sequence.
        req     = 4'b0001;
        code_in = 16'h0002;
        exp_q.push_back('{4'b0001, 2});
        @(posedge clk);
        @(negedge clk);
        play(5, 10, -1, 4'b0, 16'h0, -1);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk_idle("after_freeze");

        // Reset in the middle of OFF; pointer returns to 0.
        req     = 4'b0101;
        code_in = 16'h0201;
        exp_q.push_back('{4'b0100, 2});
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, -1, 4'b0, 16'h0, 10);
        @(negedge clk);
        chk_idle("mid_off_reset");
        rst = 1'b0;
        exp_q.push_back('{4'b0001, 1});
        @(posedge clk);
        @(negedge clk);
        play(-1, 0, -1, 4'b0, 16'h0, -1);
        req = 4'b0000;
        @(posedge clk);
        @(negedge clk);
        chk_idle("after_reset_regrant");

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
